// File: rtl/sat_counter_bank.sv
// Bank of independent bounded counters (0..MAX) with up/down, saturate/wrap,
// parallel load, overflow/underflow pulses and illegal-state self-recovery.
module sat_counter_bank #(
    parameter int WIDTH    = 3,
    parameter int MAX      = 5,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       ctr_rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       dir,
    input  logic                      wrap_mode,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       at_max,
    output logic [CHANNELS-1:0]       at_min,
    output logic [CHANNELS-1:0]       ovf,
    output logic [CHANNELS-1:0]       unf,
    output logic [CHANNELS-1:0]       err,
    output logic                      any_err
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic             ovf_q;
        logic             unf_q;
        logic [WIDTH-1:0] lv;

        assign lv = load_val[i*WIDTH +: WIDTH];

        // Bounds are compared explicitly so nothing relies on a carry out of WIDTH.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt   <= '0;
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
                if (cnt > MAX_W) begin
                    cnt <= '0;
                end else if (ctr_rst[i]) begin
                    cnt <= '0;
                end else if (load[i]) begin
                    cnt <= (lv > MAX_W) ? MAX_W : lv;
                end else if (en[i] && dir[i]) begin
                    if (cnt == MAX_W) begin
                        cnt   <= wrap_mode ? '0 : MAX_W;
                        ovf_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else if (en[i]) begin
                    if (cnt == '0) begin
                        cnt   <= wrap_mode ? MAX_W : '0;
                        unf_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            end
        end

        assign out[i*WIDTH +: WIDTH] = cnt;
        assign at_max[i]             = (cnt == MAX_W);
        assign at_min[i]             = (cnt == '0);
        assign err[i]                = (cnt > MAX_W);
        assign ovf[i]                = ovf_q;
        assign unf[i]                = unf_q;
    end

    assign any_err = |err;

endmodule

// File: tb/tb_sat_counter_bank.sv
// Self-checking bench for sat_counter_bank: default instance (3b/0..5/4ch)
// plus a 4b/0..15/2ch instance for full-range saturation and wrap.
module tb_sat_counter_bank;

    logic        clk;
    logic        rst;

    logic [3:0]  ctr_rst_a, en_a, dir_a, load_a;
    logic        wrap_a;
    logic [11:0] load_val_a, out_a;
    logic [3:0]  at_max_a, at_min_a, ovf_a, unf_a, err_a;
    logic        any_err_a;

    logic [1:0]  ctr_rst_b, en_b, dir_b, load_b;
    logic        wrap_b;
    logic [7:0]  load_val_b, out_b;
    logic [1:0]  at_max_b, at_min_b, ovf_b, unf_b, err_b;
    logic        any_err_b;

    int errors = 0;
    int checks = 0;

    sat_counter_bank dut_a (
        .clk(clk), .rst(rst), .ctr_rst(ctr_rst_a), .en(en_a), .dir(dir_a),
        .wrap_mode(wrap_a), .load(load_a), .load_val(load_val_a), .out(out_a),
        .at_max(at_max_a), .at_min(at_min_a), .ovf(ovf_a), .unf(unf_a),
        .err(err_a), .any_err(any_err_a)
    );

    sat_counter_bank #(.WIDTH(4), .MAX(15), .CHANNELS(2)) dut_b (
        .clk(clk), .rst(rst), .ctr_rst(ctr_rst_b), .en(en_b), .dir(dir_b),
        .wrap_mode(wrap_b), .load(load_b), .load_val(load_val_b), .out(out_b),
        .at_max(at_max_b), .at_min(at_min_b), .ovf(ovf_b), .unf(unf_b),
        .err(err_b), .any_err(any_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         b;
        int         ch;
        bit         wr, cr, ld;
        logic [3:0] lv;
        bit         e, d;
        logic [3:0] eo;
        bit         eovf, eunf;
    } vec_t;

    typedef struct {
        logic [11:0] out;
        logic [3:0]  ovf, unf, at_max, at_min;
    } bank_t;

    vec_t  vecs_a[$];
    vec_t  vecs_b[$];
    vec_t  sb[$];
    bank_t sbi[$];

    function automatic vec_t v(bit b, int ch, bit wr, bit cr, bit ld, logic [3:0] lv,
                               bit e, bit d, logic [3:0] eo, bit eovf, bit eunf);
        vec_t r;
        r.b = b; r.ch = ch; r.wr = wr; r.cr = cr; r.ld = ld; r.lv = lv;
        r.e = e; r.d = d; r.eo = eo; r.eovf = eovf; r.eunf = eunf;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        ctr_rst_a = '0; en_a = '0; dir_a = '0; load_a = '0; wrap_a = 1'b0; load_val_a = '0;
        ctr_rst_b = '0; en_b = '0; dir_b = '0; load_b = '0; wrap_b = 1'b0; load_val_b = '0;
    endtask

    // Reference next-state from the channel behaviour description.
    function automatic void model(input int c, input int mx, input bit cr, input bit ld,
                                  input int lv, input bit e, input bit d, input bit wr,
                                  output int n, output bit o, output bit u);
        o = 1'b0;
        u = 1'b0;
        if (c > mx)        n = 0;
        else if (cr)       n = 0;
        else if (ld)       n = (lv > mx) ? mx : lv;
        else if (e && d) begin
            if (c == mx) begin n = wr ? 0 : mx; o = 1'b1; end
            else n = c + 1;
        end else if (e) begin
            if (c == 0) begin n = wr ? mx : 0; u = 1'b1; end
            else n = c - 1;
        end else n = c;
    endfunction

    task automatic apply_vec(input vec_t t, input int idx);
        vec_t        e;
        int          mx;
        logic [31:0] o;
        @(negedge clk);
        idle();
        if (!t.b) begin
            wrap_a = t.wr; ctr_rst_a[t.ch] = t.cr; load_a[t.ch] = t.ld;
            load_val_a[t.ch*3 +: 3] = t.lv[2:0]; en_a[t.ch] = t.e; dir_a[t.ch] = t.d;
        end else begin
            wrap_b = t.wr; ctr_rst_b[t.ch] = t.cr; load_b[t.ch] = t.ld;
            load_val_b[t.ch*4 +: 4] = t.lv; en_b[t.ch] = t.e; dir_b[t.ch] = t.d;
        end
        sb.push_back(t);
        @(posedge clk);
        #1;
        e  = sb.pop_front();
        mx = e.b ? 15 : 5;
        if (!e.b) begin
            o = 32'(out_a[e.ch*3 +: 3]);
            check($sformatf("%s row%0d out", "a", idx), o, 32'(e.eo));
            check($sformatf("a row%0d ovf", idx), 32'(ovf_a[e.ch]), 32'(e.eovf));
            check($sformatf("a row%0d unf", idx), 32'(unf_a[e.ch]), 32'(e.eunf));
            check($sformatf("a row%0d at_max", idx), 32'(at_max_a[e.ch]), 32'(int'(e.eo) == mx));
            check($sformatf("a row%0d at_min", idx), 32'(at_min_a[e.ch]), 32'(e.eo == 4'd0));
            check($sformatf("a row%0d err", idx), 32'(err_a[e.ch]), 32'd0);
        end else begin
            o = 32'(out_b[e.ch*4 +: 4]);
            check($sformatf("b row%0d out", idx), o, 32'(e.eo));
            check($sformatf("b row%0d ovf", idx), 32'(ovf_b[e.ch]), 32'(e.eovf));
            check($sformatf("b row%0d unf", idx), 32'(unf_b[e.ch]), 32'(e.eunf));
            check($sformatf("b row%0d at_max", idx), 32'(at_max_b[e.ch]), 32'(int'(e.eo) == mx));
            check($sformatf("b row%0d at_min", idx), 32'(at_min_b[e.ch]), 32'(e.eo == 4'd0));
            check($sformatf("b row%0d err", idx), 32'(err_b[e.ch]), 32'd0);
        end
    endtask

    initial begin
        int    mc[4];
        int    n;
        bit    o, u;
        bank_t x, g;

        // ch0: saturate up (b, ch, wr, cr, ld, lv, e, d, eo, ovf, unf)
        for (int i = 1; i <= 7; i++)
            vecs_a.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, (i < 5) ? 4'(i) : 4'd5, i >= 6, 0));
        vecs_a.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0));
        // ch1: wrap both ways, then saturate-mode underflow
        vecs_a.push_back(v(0, 1, 1, 0, 1, 5, 0, 0, 5, 0, 0));
        vecs_a.push_back(v(0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0));
        vecs_a.push_back(v(0, 1, 1, 0, 0, 0, 1, 0, 5, 0, 1));
        vecs_a.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 5, 0, 0));
        vecs_a.push_back(v(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs_a.push_back(v(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs_a.push_back(v(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs_a.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // ch2: load clamp and priority
        vecs_a.push_back(v(0, 2, 0, 0, 1, 7, 0, 0, 5, 0, 0));
        vecs_a.push_back(v(0, 2, 0, 1, 1, 7, 1, 1, 0, 0, 0));
        vecs_a.push_back(v(0, 2, 0, 0, 1, 3, 1, 1, 3, 0, 0));
        vecs_a.push_back(v(0, 2, 0, 0, 1, 5, 0, 0, 5, 0, 0));
        vecs_a.push_back(v(0, 2, 0, 1, 0, 0, 1, 1, 0, 0, 0));
        vecs_a.push_back(v(0, 2, 0, 0, 1, 5, 1, 1, 5, 0, 0));
        vecs_a.push_back(v(0, 2, 0, 0, 0, 0, 1, 1, 5, 1, 0));
        vecs_a.push_back(v(0, 2, 0, 0, 1, 5, 1, 1, 5, 0, 0));
        vecs_a.push_back(v(0, 2, 0, 0, 0, 0, 1, 0, 4, 0, 0));
        // wide instance: saturation and wrap at 15
        vecs_b.push_back(v(1, 0, 0, 0, 1, 14, 0, 0, 14, 0, 0));
        vecs_b.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 15, 0, 0));
        vecs_b.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 15, 1, 0));
        vecs_b.push_back(v(1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0));
        vecs_b.push_back(v(1, 0, 1, 0, 0, 0, 1, 0, 15, 0, 1));
        vecs_b.push_back(v(1, 1, 0, 0, 1, 15, 0, 0, 15, 0, 0));
        vecs_b.push_back(v(1, 1, 0, 0, 1, 9, 1, 0, 9, 0, 0));
        vecs_b.push_back(v(1, 1, 0, 0, 0, 0, 1, 0, 8, 0, 0));

        idle();
        rst = 1'b0;
        #12;
        check("reset out_a", 32'(out_a), 32'd0);
        check("reset at_min_a", 32'(at_min_a), 32'hf);
        check("reset at_max_a", 32'(at_max_a), 32'd0);
        check("reset ovf_unf_a", 32'({ovf_a, unf_a}), 32'd0);
        check("reset err_a", 32'({err_a, any_err_a}), 32'd0);
        check("reset out_b", 32'(out_b), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs_a.size(); i++) apply_vec(vecs_a[i], i);

        // Illegal state on ch3: recovers to 0 despite load/count requests.
        @(negedge clk);
        idle();
        load_a[3] = 1'b1; load_val_a[11:9] = 3'd3; en_a[3] = 1'b1; dir_a[3] = 1'b1;
        force dut_a.g_ch[3].cnt = 3'd6;
        #1;
        check("illegal out", 32'(out_a[11:9]), 32'd6);
        check("illegal err", 32'(err_a[3]), 32'd1);
        check("illegal any_err", 32'(any_err_a), 32'd1);
        #1;
        release dut_a.g_ch[3].cnt;
        @(posedge clk);
        #1;
        check("recover out", 32'(out_a[11:9]), 32'd0);
        check("recover err", 32'(err_a[3]), 32'd0);
        check("recover any_err", 32'(any_err_a), 32'd0);
        check("recover ovf_unf", 32'({ovf_a[3], unf_a[3]}), 32'd0);

        // Channel independence against per-channel model.
        for (int i = 0; i < 4; i++) mc[i] = 0;
        for (int cyc = 0; cyc < 11; cyc++) begin
            @(negedge clk);
            idle();
            if (cyc == 0) ctr_rst_a = '1;
            else begin
                en_a       = 4'($urandom_range(0, 15));
                dir_a      = 4'($urandom_range(0, 15));
                ctr_rst_a  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                load_a     = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                load_val_a = 12'($urandom);
                wrap_a     = 1'($urandom_range(0, 1));
            end
            for (int ch = 0; ch < 4; ch++) begin
                model(mc[ch], 5, ctr_rst_a[ch], load_a[ch], int'(load_val_a[ch*3 +: 3]),
                      en_a[ch], dir_a[ch], wrap_a, n, o, u);
                mc[ch]          = n;
                x.out[ch*3 +: 3] = 3'(n);
                x.ovf[ch]       = o;
                x.unf[ch]       = u;
                x.at_max[ch]    = (n == 5);
                x.at_min[ch]    = (n == 0);
            end
            sbi.push_back(x);
            @(posedge clk);
            #1;
            g = sbi.pop_front();
            check($sformatf("indep%0d out", cyc), 32'(out_a), 32'(g.out));
            check($sformatf("indep%0d ovf", cyc), 32'(ovf_a), 32'(g.ovf));
            check($sformatf("indep%0d unf", cyc), 32'(unf_a), 32'(g.unf));
            check($sformatf("indep%0d flags", cyc), 32'({at_max_a, at_min_a}), 32'({g.at_max, g.at_min}));
        end

        // Async reset between edges with nonzero counts and a live ovf pulse.
        @(negedge clk);
        idle();
        load_a = 4'hf;
        load_val_a = {3'd4, 3'd3, 3'd2, 3'd5};
        @(posedge clk);
        #1;
        check("pre-reset out", 32'(out_a), 32'({3'd4, 3'd3, 3'd2, 3'd5}));
        @(negedge clk);
        idle();
        en_a = 4'b0001; dir_a = 4'b0001;
        @(posedge clk);
        #1;
        check("pre-reset ovf", 32'(ovf_a), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async out", 32'(out_a), 32'd0);
        check("async ovf_unf", 32'({ovf_a, unf_a}), 32'd0);
        check("async at_min", 32'(at_min_a), 32'hf);
        @(negedge clk);
        idle();
        rst = 1'b1;

        for (int i = 0; i < vecs_b.size(); i++) apply_vec(vecs_b[i], 100 + i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
